// File: rtl/multimode_timer_pkg.sv
// Shared types and field limits for the min/sec/msec timer.
package multimode_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam int MIN_W = 7;
  localparam int SEC_W = 6;
  localparam int MS_W  = 10;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;

endpackage

// File: rtl/multimode_timer_if.sv
// Control buttons in, time/status out; master = button/display side, slave = timer.
interface multimode_timer_if;
  import multimode_timer_pkg::*;

  logic             start;
  logic             stop;
  logic             clear;
  logic             mode;
  logic             inc_min;
  logic             dec_min;
  logic             inc_sec;
  logic             dec_sec;
  logic [MIN_W-1:0] min;
  logic [SEC_W-1:0] sec;
  logic [MS_W-1:0]  msec;
  logic             running;
  logic             expired;
  logic             alarm;

  modport master (
    output start, stop, clear, mode, inc_min, dec_min, inc_sec, dec_sec,
    input  min, sec, msec, running, expired, alarm
  );

  modport slave (
    input  start, stop, clear, mode, inc_min, dec_min, inc_sec, dec_sec,
    output min, sec, msec, running, expired, alarm
  );

endinterface

// File: rtl/multimode_timer_tick_gen.sv
// Prescaler producing a one-cycle 1 ms tick every CLK_PER_MS clocks while run is high.
module tick_gen #(
  parameter int CLK_PER_MS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_PER_MS);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo counter; holds when run is low, clr wins over run.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/multimode_timer.sv
// Countdown / count-up min:sec.msec timer with run/pause/clear, release-edge edits and timed alarm.
module multimode_timer
  import multimode_timer_pkg::*;
#(
  parameter int CLK_PER_MS = 1000,
  parameter int MAX_MIN    = 99,
  parameter int RST_MIN    = 15,
  parameter int ALARM_MS   = 10000
) (
  input logic clk,
  input logic rst,
  multimode_timer_if.slave bus
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);
  localparam logic [MIN_W-1:0] MIN_RST = MIN_W'(RST_MIN);
  localparam int AW = $clog2(ALARM_MS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_MS - 1);

  state_t           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             mode_q, mode_d;
  logic             alarm_q, alarm_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic [3:0]       prev_q;
  logic [3:0]       btn_cur;
  logic [3:0]       rel;
  logic             tick;
  logic             pre_run;
  logic             pre_clr;
  logic             time_zero;
  logic             time_full;

  assign btn_cur   = {bus.inc_min, bus.dec_min, bus.inc_sec, bus.dec_sec};
  assign rel       = prev_q & ~btn_cur;
  assign time_zero = (min_q == '0) && (sec_q == '0) && (ms_q == '0);
  assign time_full = (min_q == MIN_TOP) && (sec_q == SEC_MAX) && (ms_q == MS_MAX);

  // The prescaler is frozen on the stop edge itself so a pause never swallows a tick.
  assign pre_run = ((state_q == RUN) && !bus.stop) || (state_q == EXPIRED);
  assign pre_clr = bus.clear || (state_q == IDLE);

  tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (pre_run),
    .clr  (pre_clr),
    .tick (tick)
  );

  // Next-state, time arithmetic, edits and alarm timing; clear > stop > start > edit.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    mode_d  = mode_q;
    alarm_d = alarm_q;
    acnt_d  = acnt_q;

    if (bus.clear) begin
      state_d = IDLE;
      min_d   = '0;
      sec_d   = '0;
      ms_d    = '0;
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!bus.stop && bus.start) begin
            if (state_q == PAUSE) begin
              state_d = RUN;
            end else if (bus.mode || !time_zero) begin
              state_d = RUN;
              mode_d  = bus.mode;
            end
          end else if (!bus.stop && !bus.start) begin
            if (rel[3]) begin
              if (min_q < MIN_TOP) min_d = min_q + 1'b1;
              ms_d = '0;
            end else if (rel[2]) begin
              if (min_q != '0) min_d = min_q - 1'b1;
              ms_d = '0;
            end else if (rel[1]) begin
              sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 1'b1;
              ms_d  = '0;
            end else if (rel[0]) begin
              sec_d = (sec_q == '0) ? SEC_MAX : sec_q - 1'b1;
              ms_d  = '0;
            end
          end
        end

        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (mode_q) begin
              if (time_full) begin
                state_d = EXPIRED;
                alarm_d = 1'b1;
                acnt_d  = '0;
              end else if (ms_q != MS_MAX) begin
                ms_d = ms_q + 1'b1;
              end else begin
                ms_d = '0;
                if (sec_q != SEC_MAX) begin
                  sec_d = sec_q + 1'b1;
                end else begin
                  sec_d = '0;
                  min_d = min_q + 1'b1;
                end
              end
            end else begin
              if (ms_q != '0) begin
                ms_d = ms_q - 1'b1;
              end else if (sec_q != '0) begin
                sec_d = sec_q - 1'b1;
                ms_d  = MS_MAX;
              end else if (min_q != '0) begin
                min_d = min_q - 1'b1;
                sec_d = SEC_MAX;
                ms_d  = MS_MAX;
              end
              // A tick landing on (or already at) zero ends the countdown.
              if ((min_d == '0) && (sec_d == '0) && (ms_d == '0)) begin
                state_d = EXPIRED;
                alarm_d = 1'b1;
                acnt_d  = '0;
              end
            end
          end
        end

        EXPIRED: begin
          if (bus.stop) begin
            alarm_d = 1'b0;
          end else if (alarm_q && tick) begin
            if (acnt_q == ALARM_LAST) alarm_d = 1'b0;
            else                      acnt_d  = acnt_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Registered state, time fields, alarm and button history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      min_q   <= MIN_RST;
      sec_q   <= '0;
      ms_q    <= '0;
      mode_q  <= 1'b0;
      alarm_q <= 1'b0;
      acnt_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      mode_q  <= mode_d;
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
      prev_q  <= btn_cur;
    end
  end

  assign bus.min     = min_q;
  assign bus.sec     = sec_q;
  assign bus.msec    = ms_q;
  assign bus.running = (state_q == RUN);
  assign bus.expired = (state_q == EXPIRED);
  assign bus.alarm   = alarm_q;

endmodule
